// File: rtl/estagio_writeback.sv
// Write-back stage: MEM/WB register, source select, sub-word load extension; optional forwarding under WB_FORWARD_EN.
// Latency: 1 cycle from accept to register-file write; retiring and accepting in the same cycle keeps full throughput.
// Backpressure: in_pronto drops only while an entry is held and the register-file port is busy (wb_ocupado).
module estagio_writeback #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valido,
    output logic                  in_pronto,
    input  logic [DATA_W-1:0]     in_memDado,
    input  logic [DATA_W-1:0]     in_aluResultado,
    input  logic [DATA_W-1:0]     in_pcMais4,
    input  logic [REG_ADDR_W-1:0] in_regDestino,
    input  logic [1:0]            in_selWB,
    input  logic                  in_escreveReg,
    input  logic [1:0]            in_tamanho,
    input  logic                  in_semSinal,
    input  logic                  flush,
    input  logic                  wb_ocupado,
    output logic                  wb_habilita,
    output logic [REG_ADDR_W-1:0] wb_endereco,
    output logic [DATA_W-1:0]     wb_dado,
    output logic                  fwd_valido,
    output logic [REG_ADDR_W-1:0] fwd_endereco,
    output logic [DATA_W-1:0]     fwd_dado,
    output logic [31:0]           retiradas
);

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    estado_t               estado;
    logic                  cheio;
    logic                  escreve_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]     dado_q;

    logic                  aceita;
    logic                  retira;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_W-1:0]     mem_ext;
    logic [DATA_W-1:0]     valor;

    assign cheio     = (estado == CHEIO);
    assign in_pronto = ~cheio | ~wb_ocupado;
    assign aceita    = in_valido & in_pronto & ~flush;
    assign retira    = cheio & ~wb_ocupado;

    // Little-endian lane selection driven by the low address bits of the effective address.
    always_comb begin
        byte_sel = 8'h00;
        case (in_aluResultado[1:0])
            2'd0:    byte_sel = in_memDado[7:0];
            2'd1:    byte_sel = in_memDado[15:8];
            2'd2:    byte_sel = in_memDado[23:16];
            default: byte_sel = in_memDado[31:24];
        endcase
        half_sel = in_aluResultado[1] ? in_memDado[31:16] : in_memDado[15:0];

        mem_ext = in_memDado;
        case (in_tamanho)
            2'b01: mem_ext = in_semSinal ? {{(DATA_W-16){1'b0}}, half_sel}
                                         : {{(DATA_W-16){half_sel[15]}}, half_sel};
            2'b10: mem_ext = in_semSinal ? {{(DATA_W-8){1'b0}}, byte_sel}
                                         : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            default: mem_ext = in_memDado;
        endcase

        valor = in_aluResultado;
        case (in_selWB)
            2'b01:   valor = mem_ext;
            2'b10:   valor = in_pcMais4;
            default: valor = in_aluResultado;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= VAZIO;
            escreve_q <= 1'b0;
            rd_q      <= '0;
            dado_q    <= '0;
            retiradas <= 32'd0;
        end else begin
            if (retira) begin
                retiradas <= retiradas + 32'd1;
            end
            // Flush discards the held entry and blocks the incoming one, even while the port is busy.
            if (flush) begin
                estado <= VAZIO;
            end else if (aceita) begin
                estado    <= CHEIO;
                escreve_q <= in_escreveReg;
                rd_q      <= in_regDestino;
                dado_q    <= valor;
            end else if (retira) begin
                estado <= VAZIO;
            end
        end
    end

    assign wb_habilita = cheio & escreve_q & (rd_q != '0) & ~wb_ocupado;
    assign wb_endereco = rd_q;
    assign wb_dado     = dado_q;

`ifdef WB_FORWARD_EN
    assign fwd_valido   = cheio & escreve_q & (rd_q != '0);
    assign fwd_endereco = rd_q;
    assign fwd_dado     = dado_q;
`else
    assign fwd_valido   = 1'b0;
    assign fwd_endereco = '0;
    assign fwd_dado     = '0;
`endif

endmodule

// File: tb/tb_estagio_writeback.sv
// Scoreboard bench for estagio_writeback: expected writes are queued at accept, a negedge monitor pops and compares.
module tb_estagio_writeback;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valido;
    logic        in_pronto;
    logic [31:0] in_memDado;
    logic [31:0] in_aluResultado;
    logic [31:0] in_pcMais4;
    logic [4:0]  in_regDestino;
    logic [1:0]  in_selWB;
    logic        in_escreveReg;
    logic [1:0]  in_tamanho;
    logic        in_semSinal;
    logic        flush;
    logic        wb_ocupado;
    logic        wb_habilita;
    logic [4:0]  wb_endereco;
    logic [31:0] wb_dado;
    logic        fwd_valido;
    logic [4:0]  fwd_endereco;
    logic [31:0] fwd_dado;
    logic [31:0] retiradas;

    int errors  = 0;
    int checks  = 0;
    int nwrites = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    estagio_writeback #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valido(in_valido), .in_pronto(in_pronto),
        .in_memDado(in_memDado), .in_aluResultado(in_aluResultado), .in_pcMais4(in_pcMais4),
        .in_regDestino(in_regDestino), .in_selWB(in_selWB), .in_escreveReg(in_escreveReg),
        .in_tamanho(in_tamanho), .in_semSinal(in_semSinal),
        .flush(flush), .wb_ocupado(wb_ocupado),
        .wb_habilita(wb_habilita), .wb_endereco(wb_endereco), .wb_dado(wb_dado),
        .fwd_valido(fwd_valido), .fwd_endereco(fwd_endereco), .fwd_dado(fwd_dado),
        .retiradas(retiradas)
    );

    always #5 clock = ~clock;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Monitor: every register-file write must match the oldest queued expectation.
    always @(negedge clock) begin
        if (reset === 1'b0 && wb_habilita === 1'b1) begin
            nwrites++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         wb_endereco, wb_dado);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_endereco", 32'(wb_endereco), 32'(mon_e.a));
                chk("wb_dado", wb_dado, mon_e.d);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Presents one instruction and holds it until accepted; queues the expected write when expw is set.
    task automatic issue(input logic [1:0] sel, input logic [31:0] mem, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic wr,
                         input logic [1:0] tam, input logic sem, input logic [31:0] expv,
                         input bit expw);
        int   n;
        bit   ok;
        exp_t tmp;
        in_selWB        = sel;
        in_memDado      = mem;
        in_aluResultado = alu;
        in_pcMais4      = pc4;
        in_regDestino   = rd;
        in_escreveReg   = wr;
        in_tamanho      = tam;
        in_semSinal     = sem;
        in_valido       = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clock);
            ok = (in_pronto === 1'b1);
            @(posedge clock);
            #1;
            n++;
        end
        in_valido = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no accept in 20 cycles for rd %0d, expected accept", rd);
        end else if (expw) begin
            tmp.a = rd;
            tmp.d = expv;
            sb.push_back(tmp);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valido = 1'b0; in_memDado = '0; in_aluResultado = '0; in_pcMais4 = '0;
        in_regDestino = '0; in_selWB = '0; in_escreveReg = 1'b0; in_tamanho = '0;
        in_semSinal = 1'b0; flush = 1'b0; wb_ocupado = 1'b0;

        #2;
        chk("rst_pronto", 32'(in_pronto), 32'd1);
        chk("rst_habilita", 32'(wb_habilita), 32'd0);
        chk("rst_retiradas", retiradas, 32'd0);
        chk("rst_dado", wb_dado, 32'd0);
        chk("rst_fwd_valido", 32'(fwd_valido), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1);

        // Word load
        issue(2'b01, 32'h8000_00F0, 32'h0000_0100, 32'h4, 5'd5, 1'b1, 2'b00, 1'b0, 32'h8000_00F0, 1'b1);
        @(negedge clock);
        chk("word_habilita", 32'(wb_habilita), 32'd1);
`ifdef WB_FORWARD_EN
        chk("word_fwd_valido", 32'(fwd_valido), 32'd1);
        chk("word_fwd_dado", fwd_dado, 32'h8000_00F0);
`else
        chk("word_fwd_valido", 32'(fwd_valido), 32'd0);
        chk("word_fwd_dado", fwd_dado, 32'd0);
`endif
        @(posedge clock);
        #1;
        chk("word_retiradas", retiradas, 32'd1);

        // Sub-word loads and source select, back to back
        issue(2'b01, 32'h12F4_5678, 32'h2, 32'h0, 5'd6,  1'b1, 2'b10, 1'b0, 32'hFFFF_FFF4, 1'b1);
        issue(2'b01, 32'h12F4_5678, 32'h2, 32'h0, 5'd7,  1'b1, 2'b10, 1'b1, 32'h0000_00F4, 1'b1);
        issue(2'b01, 32'h8001_0000, 32'h2, 32'h0, 5'd8,  1'b1, 2'b01, 1'b0, 32'hFFFF_8001, 1'b1);
        issue(2'b01, 32'h1234_ABCD, 32'h0, 32'h0, 5'd9,  1'b1, 2'b01, 1'b1, 32'h0000_ABCD, 1'b1);
        issue(2'b01, 32'h12F4_5678, 32'h3, 32'h0, 5'd10, 1'b1, 2'b10, 1'b0, 32'h0000_0012, 1'b1);
        issue(2'b01, 32'h8001_7FFF, 32'h3, 32'h0, 5'd3,  1'b1, 2'b01, 1'b0, 32'hFFFF_8001, 1'b1);
        issue(2'b10, 32'h5555_5555, 32'h6666_6666, 32'h0000_0404, 5'd31, 1'b1, 2'b10, 1'b0, 32'h0000_0404, 1'b1);
        issue(2'b11, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0000_0022, 5'd2, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1);
        cyc(1);
        chk("sub_retiradas", retiradas, 32'd9);

        // Stall for 3 cycles, then release with the next entry waiting
        issue(2'b00, 32'h0, 32'h0000_AAAA, 32'h0, 5'd11, 1'b1, 2'b00, 1'b0, 32'h0000_AAAA, 1'b1);
        wb_ocupado = 1'b1;
        in_selWB = 2'b00; in_aluResultado = 32'h0000_BBBB; in_regDestino = 5'd13;
        in_escreveReg = 1'b1; in_valido = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_pronto", 32'(in_pronto), 32'd0);
            chk("stall_habilita", 32'(wb_habilita), 32'd0);
            chk("stall_endereco", 32'(wb_endereco), 32'd11);
            chk("stall_dado", wb_dado, 32'h0000_AAAA);
            @(posedge clock);
            #1;
        end
        wb_ocupado = 1'b0;
        @(negedge clock);
        chk("release_pronto", 32'(in_pronto), 32'd1);
        @(posedge clock);
        #1;
        mon_e.a = 5'd13;
        mon_e.d = 32'h0000_BBBB;
        sb.push_back(mon_e);
        in_valido = 1'b0;
        @(negedge clock);
        chk("nobubble_habilita", 32'(wb_habilita), 32'd1);
        chk("nobubble_endereco", 32'(wb_endereco), 32'd13);
        @(posedge clock);
        #1;
        chk("stall_retiradas", retiradas, 32'd11);

        // Write to r0: suppressed but retired
        issue(2'b00, 32'h0, 32'h0000_1234, 32'h0, 5'd0, 1'b1, 2'b00, 1'b0, 32'h0000_1234, 1'b0);
        @(negedge clock);
        chk("r0_habilita", 32'(wb_habilita), 32'd0);
        chk("r0_dado", wb_dado, 32'h0000_1234);
        @(posedge clock);
        #1;
        chk("r0_retiradas", retiradas, 32'd12);

        // Flush with a busy port and a valid incoming instruction
        issue(2'b00, 32'h0, 32'h0000_CCCC, 32'h0, 5'd12, 1'b1, 2'b00, 1'b0, 32'h0000_CCCC, 1'b0);
        wb_ocupado = 1'b1;
        flush = 1'b1;
        in_aluResultado = 32'h0000_DDDD; in_regDestino = 5'd14; in_valido = 1'b1;
        @(negedge clock);
        chk("flush_habilita_busy", 32'(wb_habilita), 32'd0);
`ifdef WB_FORWARD_EN
        chk("flush_fwd_before", 32'(fwd_valido), 32'd1);
`else
        chk("flush_fwd_before", 32'(fwd_valido), 32'd0);
`endif
        @(posedge clock);
        #1;
        flush = 1'b0; in_valido = 1'b0; wb_ocupado = 1'b0;
        @(negedge clock);
        chk("flush_pronto", 32'(in_pronto), 32'd1);
        chk("flush_habilita", 32'(wb_habilita), 32'd0);
        chk("flush_fwd_after", 32'(fwd_valido), 32'd0);
        @(posedge clock);
        #1;
        chk("flush_retiradas", retiradas, 32'd12);

        // Asynchronous reset pulse mid-cycle while an entry is held
        issue(2'b00, 32'h0, 32'h0000_EEEE, 32'h0, 5'd15, 1'b1, 2'b00, 1'b0, 32'h0000_EEEE, 1'b0);
        wb_ocupado = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_pronto", 32'(in_pronto), 32'd1);
        chk("arst_habilita", 32'(wb_habilita), 32'd0);
        chk("arst_retiradas", retiradas, 32'd0);
        chk("arst_endereco", 32'(wb_endereco), 32'd0);
        chk("arst_dado", wb_dado, 32'd0);
        chk("arst_fwd_valido", 32'(fwd_valido), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("arst_pronto_after", 32'(in_pronto), 32'd1);
        wb_ocupado = 1'b0;
        cyc(2);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("write_count", 32'(nwrites), 32'd11);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
